// File: rtl/alu_shift_unit.sv
// Iterative shifter feeding the ALU B operand for LSL/LSR.
// It shifts the operand STEP bit positions per clock, and a small IDLE/SHIFT/DONE FSM sequences the shift.
module alu_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               dir_i,
  input  logic               arith_i,
  input  logic [WIDTH-1:0]   data_in_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   result_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

  state_t             state_q;
  logic [WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]   work_d;
  logic [WIDTH-1:0]   result_q;
  logic [SHAMT_W-1:0] remaining_q;
  logic [SHAMT_W-1:0] remaining_d;
  logic               dir_q;
  logic               arith_q;
  logic               sign_q;
  logic               fill;

  // Each iteration moves the operand by one bit, but only while bits remain to be shifted.
  // The final cycle therefore shifts by min(STEP, remaining).
  always_comb begin
    fill   = arith_q & sign_q;
    work_d = work_q;
    for (int i = 0; i < STEP; i++) begin
      if (SHAMT_W'(i) < remaining_q) begin
        if (dir_q) work_d = {fill, work_d[WIDTH-1:1]};
        else       work_d = {work_d[WIDTH-2:0], 1'b0};
      end
    end
    remaining_d = (remaining_q < STEP_AMT) ? '0 : remaining_q - STEP_AMT;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      work_q      <= '0;
      result_q    <= '0;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      arith_q     <= 1'b0;
      sign_q      <= 1'b0;
    end else begin
      case (state_q)
        // DONE accepts a new request exactly like IDLE, so ops can run back-to-back.
        IDLE, DONE: begin
          if (start_i) begin
            work_q      <= data_in_i;
            remaining_q <= shamt_i;
            dir_q       <= dir_i;
            arith_q     <= arith_i;
            sign_q      <= data_in_i[WIDTH-1];
            if (shamt_i == '0) begin
              result_q <= data_in_i;
              state_q  <= DONE;
            end else begin
              state_q  <= SHIFT;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          work_q      <= work_d;
          remaining_q <= remaining_d;
          if (remaining_d == '0) begin
            result_q <= work_d;
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o   = (state_q == SHIFT);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_alu_shift_unit.sv
// Self-checking bench for alu_shift_unit (STEP=1).
// Directed vector table, hand-written back-to-back and abort sequences, then random ops against a reference model.
module tb_alu_shift_unit;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int STEP    = 1;

  logic               clk;
  logic               reset;
  logic               start;
  logic               dir;
  logic               arith;
  logic [WIDTH-1:0]   dataIn;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] lastResult = '0;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               amt;
    logic             dr;
    logic             ar;
    logic [WIDTH-1:0] expected;
  } vec_t;

  alu_shift_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .STEP(STEP)) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .start_i   (start),
    .dir_i     (dir),
    .arith_i   (arith),
    .data_in_i (dataIn),
    .shamt_i   (shamt),
    .busy_o    (busy),
    .done_o    (done),
    .result_o  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour expressed with the language's own shift operators.
  function automatic logic [WIDTH-1:0] refShift(logic [WIDTH-1:0] d, int s, logic dr, logic ar);
    if (!dr) return d << s;
    if (ar)  return WIDTH'($signed(d) >>> s);
    return d >> s;
  endfunction

  task automatic checkOutput(string name, logic [WIDTH-1:0] actual, logic [WIDTH-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // One complete op: drive at a negedge, accept at the next posedge, then count cycles to done.
  task automatic applyStimulus(string name, logic [WIDTH-1:0] d, int s, logic dr, logic ar,
                               logic [WIDTH-1:0] expected);
    int cycles;
    bit busyOk;
    bit holdOk;
    @(negedge clk);
    start  = 1'b1;
    dataIn = d;
    shamt  = SHAMT_W'(s);
    dir    = dr;
    arith  = ar;
    @(negedge clk);
    start  = 1'b0;
    dataIn = $urandom;
    shamt  = SHAMT_W'($urandom);
    dir    = 1'($urandom);
    arith  = 1'($urandom);
    cycles = 0;
    busyOk = 1'b1;
    holdOk = 1'b1;
    while (!done && cycles < 100) begin
      if (busy !== 1'b1) busyOk = 1'b0;
      if (result !== lastResult) holdOk = 1'b0;
      @(negedge clk);
      cycles++;
    end
    checkOutput({name, " done"}, WIDTH'(done), WIDTH'(1));
    checkOutput({name, " latency"}, WIDTH'(cycles), WIDTH'((s + STEP - 1) / STEP));
    checkOutput({name, " busy while shifting"}, WIDTH'(busyOk), WIDTH'(1));
    checkOutput({name, " result held"}, WIDTH'(holdOk), WIDTH'(1));
    checkOutput({name, " busy in done"}, WIDTH'(busy), WIDTH'(0));
    checkOutput({name, " result"}, result, expected);
    lastResult = expected;
  endtask

  initial begin
    vec_t vecs[$];
    logic [WIDTH-1:0] d;
    int s;
    logic dr;
    logic ar;
    bit sawDone;

    vecs.push_back('{32'h0000_00F1, 4,  1'b0, 1'b0, 32'h0000_0F10});
    vecs.push_back('{32'h8000_0000, 31, 1'b1, 1'b1, 32'hFFFF_FFFF});
    vecs.push_back('{32'h8000_0000, 31, 1'b1, 1'b0, 32'h0000_0001});
    vecs.push_back('{32'hDEAD_BEEF, 0,  1'b1, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{32'h0000_0001, 31, 1'b0, 1'b1, 32'h8000_0000});
    vecs.push_back('{32'hF000_000F, 8,  1'b1, 1'b1, 32'hFFF0_0000});
    vecs.push_back('{32'h7000_000F, 3,  1'b1, 1'b1, 32'h0E00_0001});

    reset  = 1'b1;
    start  = 1'b1;
    dir    = 1'b0;
    arith  = 1'b0;
    dataIn = 32'h1234_5678;
    shamt  = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("reset busy", WIDTH'(busy), WIDTH'(0));
      checkOutput("reset done", WIDTH'(done), WIDTH'(0));
      checkOutput("reset result", result, '0);
    end
    start = 1'b0;
    reset = 1'b0;

    foreach (vecs[i])
      applyStimulus($sformatf("vec%0d", i), vecs[i].data, vecs[i].amt, vecs[i].dr, vecs[i].ar,
                    vecs[i].expected);

    // Back-to-back with start held high; B's inputs are presented during A's SHIFT.
    @(negedge clk);
    start = 1'b1; dataIn = 32'h1; shamt = 5'd2; dir = 1'b0; arith = 1'b0;
    @(negedge clk);
    dataIn = 32'h8; shamt = 5'd1; dir = 1'b1;
    checkOutput("b2b A busy1", WIDTH'(busy), WIDTH'(1));
    @(negedge clk);
    checkOutput("b2b A busy2", WIDTH'(busy), WIDTH'(1));
    checkOutput("b2b A not done", WIDTH'(done), WIDTH'(0));
    @(negedge clk);
    checkOutput("b2b A done", WIDTH'(done), WIDTH'(1));
    checkOutput("b2b A result", result, 32'h4);
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b B busy", WIDTH'(busy), WIDTH'(1));
    checkOutput("b2b done not extended", WIDTH'(done), WIDTH'(0));
    @(negedge clk);
    checkOutput("b2b B done", WIDTH'(done), WIDTH'(1));
    checkOutput("b2b B result", result, 32'h4);
    lastResult = 32'h4;

    // Abort: reset during the third SHIFT cycle of a 10-bit shift.
    @(negedge clk);
    start = 1'b1; dataIn = 32'hFFFF_0000; shamt = 5'd10; dir = 1'b1; arith = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort busy before", WIDTH'(busy), WIDTH'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort busy", WIDTH'(busy), WIDTH'(0));
    checkOutput("abort result", result, '0);
    sawDone = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) sawDone = 1'b1;
      @(negedge clk);
    end
    checkOutput("abort no done", WIDTH'(sawDone), WIDTH'(0));
    lastResult = '0;
    applyStimulus("after abort", 32'h0000_00F1, 4, 1'b0, 1'b0, 32'h0000_0F10);

    for (int i = 0; i < 40; i++) begin
      d  = $urandom;
      s  = $urandom_range(0, WIDTH - 1);
      dr = 1'($urandom);
      ar = 1'($urandom);
      applyStimulus($sformatf("rand%0d", i), d, s, dr, ar, refShift(d, s, dr, ar));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
